// File: rtl/pdh_adc_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : pdh_adc_frontend
//  Purpose  : Registers both ADC channels, converts offset binary to two's
//             complement, applies power-of-two boxcar averaging/decimation
//             and reports clipping via sticky flags and a saturating counter.
//  Revision : 1.0  initial release
// ============================================================================
module pdh_adc_frontend #(
    parameter int ADC_WIDTH    = 14,
    parameter int OUT_WIDTH    = 16,
    parameter int DEC_LOG2_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADC_WIDTH-1:0] adc_dat_a_i,
    input  logic [ADC_WIDTH-1:0] adc_dat_b_i,
    input  logic [2:0]           dec_log2_i,
    input  logic                 clr_i,
    output logic [OUT_WIDTH-1:0] out_a_o,
    output logic [OUT_WIDTH-1:0] out_b_o,
    output logic                 out_valid_o,
    output logic                 ovr_a_o,
    output logic                 ovr_b_o,
    output logic [15:0]          ovr_cnt_o
);

    localparam int                    ACC_WIDTH   = ADC_WIDTH + DEC_LOG2_MAX;
    localparam logic [ADC_WIDTH-1:0]  c_code_min  = '0;
    localparam logic [ADC_WIDTH-1:0]  c_code_max  = '1;
    localparam logic [2:0]            c_n_max     = 3'(DEC_LOG2_MAX);
    localparam logic [DEC_LOG2_MAX:0] c_one       = (DEC_LOG2_MAX+1)'(1);
    localparam logic [DEC_LOG2_MAX-1:0] c_cnt_one = DEC_LOG2_MAX'(1);
    localparam logic [15:0]           c_ovr_max   = 16'hFFFF;
    localparam logic [15:0]           c_ovr_one   = 16'd1;

    logic [ADC_WIDTH-1:0]        r_s1_a;
    logic [ADC_WIDTH-1:0]        r_s1_b;
    logic                        r_s1_vld;
    logic signed [ADC_WIDTH-1:0] r_s2_a;
    logic signed [ADC_WIDTH-1:0] r_s2_b;
    logic                        r_s2_vld;

    logic [DEC_LOG2_MAX-1:0]     r_cnt;
    logic [2:0]                  r_n;
    logic signed [ACC_WIDTH-1:0] r_acc_a;
    logic signed [ACC_WIDTH-1:0] r_acc_b;

    logic [OUT_WIDTH-1:0]        r_out_a;
    logic [OUT_WIDTH-1:0]        r_out_b;
    logic                        r_out_vld;
    logic                        r_ovr_a;
    logic                        r_ovr_b;
    logic [15:0]                 r_ovr_cnt;

    logic                        w_clip_a;
    logic                        w_clip_b;
    logic                        w_clip_any;
    logic [2:0]                  w_n_req;
    logic [2:0]                  w_n;
    logic [DEC_LOG2_MAX-1:0]     w_blk_last;
    logic                        w_blk_end;
    logic signed [ACC_WIDTH-1:0] w_samp_a;
    logic signed [ACC_WIDTH-1:0] w_samp_b;
    logic signed [ACC_WIDTH-1:0] w_base_a;
    logic signed [ACC_WIDTH-1:0] w_base_b;
    logic signed [ACC_WIDTH-1:0] w_sum_a;
    logic signed [ACC_WIDTH-1:0] w_sum_b;
    logic signed [ADC_WIDTH-1:0] w_avg_a;
    logic signed [ADC_WIDTH-1:0] w_avg_b;

    // S1 captures the pins directly; S2 flips the MSB (offset binary -> 2's complement)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_vld <= 1'b0;
            r_s2_a   <= '0;
            r_s2_b   <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_a   <= adc_dat_a_i;
            r_s1_b   <= adc_dat_b_i;
            r_s1_vld <= 1'b1;
            r_s2_a   <= {~r_s1_a[ADC_WIDTH-1], r_s1_a[ADC_WIDTH-2:0]};
            r_s2_b   <= {~r_s1_b[ADC_WIDTH-1], r_s1_b[ADC_WIDTH-2:0]};
            r_s2_vld <= r_s1_vld;
        end
    end

    // S1 resets to code 0, which would look clipped, so gate with its valid bit
    assign w_clip_a   = r_s1_vld && (r_s1_a == c_code_min || r_s1_a == c_code_max);
    assign w_clip_b   = r_s1_vld && (r_s1_b == c_code_min || r_s1_b == c_code_max);
    assign w_clip_any = w_clip_a || w_clip_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_a   <= 1'b0;
            r_ovr_b   <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_ovr_a <= w_clip_a || (r_ovr_a && !clr_i);
            r_ovr_b <= w_clip_b || (r_ovr_b && !clr_i);
            if (w_clip_any) begin
                if (clr_i)
                    r_ovr_cnt <= c_ovr_one;
                else if (r_ovr_cnt != c_ovr_max)
                    r_ovr_cnt <= r_ovr_cnt + c_ovr_one;
            end else if (clr_i) begin
                r_ovr_cnt <= '0;
            end
        end
    end

    // The live request only matters at block start; mid-block the latched N rules
    assign w_n_req    = (dec_log2_i > c_n_max) ? c_n_max : dec_log2_i;
    assign w_n        = (r_cnt == '0) ? w_n_req : r_n;
    assign w_blk_last = DEC_LOG2_MAX'((c_one << w_n) - c_one);
    assign w_blk_end  = (r_cnt == w_blk_last);

    assign w_samp_a = {{DEC_LOG2_MAX{r_s2_a[ADC_WIDTH-1]}}, r_s2_a};
    assign w_samp_b = {{DEC_LOG2_MAX{r_s2_b[ADC_WIDTH-1]}}, r_s2_b};
    assign w_base_a = (r_cnt == '0) ? '0 : r_acc_a;
    assign w_base_b = (r_cnt == '0) ? '0 : r_acc_b;
    assign w_sum_a  = w_base_a + w_samp_a;
    assign w_sum_b  = w_base_b + w_samp_b;
    assign w_avg_a  = ADC_WIDTH'(w_sum_a >>> w_n);
    assign w_avg_b  = ADC_WIDTH'(w_sum_b >>> w_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_n       <= '0;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_n       <= w_n;
            r_out_vld <= r_s2_vld && w_blk_end;
            if (r_s2_vld) begin
                r_acc_a <= w_sum_a;
                r_acc_b <= w_sum_b;
                r_cnt   <= w_blk_end ? '0 : r_cnt + c_cnt_one;
                if (w_blk_end) begin
                    r_out_a <= {{(OUT_WIDTH-ADC_WIDTH){w_avg_a[ADC_WIDTH-1]}}, w_avg_a};
                    r_out_b <= {{(OUT_WIDTH-ADC_WIDTH){w_avg_b[ADC_WIDTH-1]}}, w_avg_b};
                end
            end
        end
    end

    assign out_a_o     = r_out_a;
    assign out_b_o     = r_out_b;
    assign out_valid_o = r_out_vld;
    assign ovr_a_o     = r_ovr_a;
    assign ovr_b_o     = r_ovr_b;
    assign ovr_cnt_o   = r_ovr_cnt;

endmodule
`default_nettype wire
